// File: rtl/ex_mem_stage_if.sv
// EX->MEM pipeline bundle: execute-side inputs, MEM-side payload, redirect,
// forwarding and exception signals. The stage itself uses the slave modport.
interface ex_mem_stage_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [XLEN-1:0]       alu_res;
   logic                  alu_zero;
   logic                  alu_illegal;
   logic [XLEN-1:0]       in_pc;
   logic [REG_ADDR_W-1:0] in_rd;
   logic                  in_regwrite;
   logic                  in_memread;
   logic                  in_memwrite;
   logic [XLEN-1:0]       in_store_data;
   logic [1:0]            in_br_type;
   logic [XLEN-1:0]       in_br_target;
   logic                  flush;

   logic                  out_valid;
   logic                  out_ready;
   logic [XLEN-1:0]       out_res;
   logic [XLEN-1:0]       out_store_data;
   logic [REG_ADDR_W-1:0] out_rd;
   logic                  out_regwrite;
   logic                  out_memread;
   logic                  out_memwrite;

   logic                  redirect;
   logic [XLEN-1:0]       redirect_pc;

   logic                  fwd_en;
   logic [REG_ADDR_W-1:0] fwd_rd;
   logic [XLEN-1:0]       fwd_data;

   logic                  exc_pending;
   logic [XLEN-1:0]       exc_pc;
   logic                  exc_ack;

   modport master (
      output in_valid, alu_res, alu_zero, alu_illegal, in_pc, in_rd,
             in_regwrite, in_memread, in_memwrite, in_store_data,
             in_br_type, in_br_target, flush, out_ready, exc_ack,
      input  in_ready, out_valid, out_res, out_store_data, out_rd,
             out_regwrite, out_memread, out_memwrite, redirect, redirect_pc,
             fwd_en, fwd_rd, fwd_data, exc_pending, exc_pc
   );

   modport slave (
      input  in_valid, alu_res, alu_zero, alu_illegal, in_pc, in_rd,
             in_regwrite, in_memread, in_memwrite, in_store_data,
             in_br_type, in_br_target, flush, out_ready, exc_ack,
      output in_ready, out_valid, out_res, out_store_data, out_rd,
             out_regwrite, out_memread, out_memwrite, redirect, redirect_pc,
             fwd_en, fwd_rd, fwd_data, exc_pending, exc_pc
   );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU output and metadata, resolves branches
// into a one-cycle redirect, and turns illegal ops into a sticky exception.
module ex_mem_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input logic           clk,
   input logic           rst_n,
   ex_mem_stage_if.slave bus
);
   logic                  out_valid_reg,      out_valid_next;
   logic [XLEN-1:0]       out_res_reg,        out_res_next;
   logic [XLEN-1:0]       out_store_data_reg, out_store_data_next;
   logic [REG_ADDR_W-1:0] out_rd_reg,         out_rd_next;
   logic                  out_regwrite_reg,   out_regwrite_next;
   logic                  out_memread_reg,    out_memread_next;
   logic                  out_memwrite_reg,   out_memwrite_next;
   logic                  redirect_reg,       redirect_next;
   logic [XLEN-1:0]       redirect_pc_reg,    redirect_pc_next;
   logic                  exc_pending_reg,    exc_pending_next;
   logic [XLEN-1:0]       exc_pc_reg,         exc_pc_next;

   logic in_ready;
   logic accept;
   logic taken;

   // Readiness depends only on registered state, never on in_valid.
   assign in_ready = !exc_pending_reg && (!out_valid_reg || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;
   assign taken    = ((bus.in_br_type == 2'd1) &&  bus.alu_zero) ||
                     ((bus.in_br_type == 2'd2) && !bus.alu_zero) ||
                      (bus.in_br_type == 2'd3);

   always_comb begin
      out_valid_next      = out_valid_reg;
      out_res_next        = out_res_reg;
      out_store_data_next = out_store_data_reg;
      out_rd_next         = out_rd_reg;
      out_regwrite_next   = out_regwrite_reg;
      out_memread_next    = out_memread_reg;
      out_memwrite_next   = out_memwrite_reg;
      redirect_next       = 1'b0;
      redirect_pc_next    = '0;
      exc_pending_next    = exc_pending_reg;
      exc_pc_next         = exc_pc_reg;

      if (accept) begin
         if (bus.flush || bus.alu_illegal) begin
            // Bubble: no writeback, no memory access, no redirect.
            out_valid_next    = 1'b0;
            out_regwrite_next = 1'b0;
            out_memread_next  = 1'b0;
            out_memwrite_next = 1'b0;
            if (!bus.flush) begin
               exc_pending_next = 1'b1;
               exc_pc_next      = bus.in_pc;
            end
         end else begin
            out_valid_next      = 1'b1;
            out_res_next        = bus.alu_res;
            out_store_data_next = bus.in_store_data;
            out_rd_next         = bus.in_rd;
            out_regwrite_next   = bus.in_regwrite;
            out_memread_next    = bus.in_memread;
            out_memwrite_next   = bus.in_memwrite;
            redirect_next       = taken;
            redirect_pc_next    = taken ? bus.in_br_target : '0;
         end
      end else if (out_valid_reg && bus.out_ready) begin
         out_valid_next = 1'b0;
      end

      // No accept can happen while pending, so set and clear never collide.
      if (exc_pending_reg && bus.exc_ack) begin
         exc_pending_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg      <= 1'b0;
         out_res_reg        <= '0;
         out_store_data_reg <= '0;
         out_rd_reg         <= '0;
         out_regwrite_reg   <= 1'b0;
         out_memread_reg    <= 1'b0;
         out_memwrite_reg   <= 1'b0;
         redirect_reg       <= 1'b0;
         redirect_pc_reg    <= '0;
         exc_pending_reg    <= 1'b0;
         exc_pc_reg         <= '0;
      end else begin
         out_valid_reg      <= out_valid_next;
         out_res_reg        <= out_res_next;
         out_store_data_reg <= out_store_data_next;
         out_rd_reg         <= out_rd_next;
         out_regwrite_reg   <= out_regwrite_next;
         out_memread_reg    <= out_memread_next;
         out_memwrite_reg   <= out_memwrite_next;
         redirect_reg       <= redirect_next;
         redirect_pc_reg    <= redirect_pc_next;
         exc_pending_reg    <= exc_pending_next;
         exc_pc_reg         <= exc_pc_next;
      end
   end

   assign bus.in_ready       = in_ready;
   assign bus.out_valid      = out_valid_reg;
   assign bus.out_res        = out_res_reg;
   assign bus.out_store_data = out_store_data_reg;
   assign bus.out_rd         = out_rd_reg;
   assign bus.out_regwrite   = out_regwrite_reg;
   assign bus.out_memread    = out_memread_reg;
   assign bus.out_memwrite   = out_memwrite_reg;
   assign bus.redirect       = redirect_reg;
   assign bus.redirect_pc    = redirect_pc_reg;
   assign bus.exc_pending    = exc_pending_reg;
   assign bus.exc_pc         = exc_pc_reg;

   // Forwarding taps the registered payload only.
   assign bus.fwd_en   = out_valid_reg && out_regwrite_reg && (out_rd_reg != '0);
   assign bus.fwd_rd   = out_rd_reg;
   assign bus.fwd_data = out_res_reg;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: expected payloads are queued when an
// instruction is accepted and checked when the MEM stage takes them.
module tb_ex_mem_stage;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef struct {
      logic [XLEN-1:0]       res;
      logic [XLEN-1:0]       sdata;
      logic [REG_ADDR_W-1:0] rd;
      logic [2:0]            ctl;
   } exp_t;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   exp_t sb[$];

   ex_mem_stage_if #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) bus ();

   ex_mem_stage #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] res, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic mw, input logic [31:0] sdata,
                        input logic [1:0] br, input logic zero, input logic ill,
                        input logic [31:0] pc, input logic [31:0] tgt, input logic fl);
      bus.in_valid      = 1'b1;
      bus.alu_res       = res;
      bus.in_rd         = rd;
      bus.in_regwrite   = rw;
      bus.in_memread    = mr;
      bus.in_memwrite   = mw;
      bus.in_store_data = sdata;
      bus.in_br_type    = br;
      bus.alu_zero      = zero;
      bus.alu_illegal   = ill;
      bus.in_pc         = pc;
      bus.in_br_target  = tgt;
      bus.flush         = fl;
   endtask

   task automatic push(input logic [31:0] res, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic mw, input logic [31:0] sdata);
      exp_t e;
      e.res   = res;
      e.sdata = sdata;
      e.rd    = rd;
      e.ctl   = {rw, mr, mw};
      sb.push_back(e);
   endtask

   task automatic idle();
      bus.in_valid    = 1'b0;
      bus.alu_illegal = 1'b0;
      bus.flush       = 1'b0;
      bus.in_br_type  = 2'd0;
   endtask

   // Scores a MEM-side transfer if one happens at the coming edge, then advances.
   task automatic tick();
      exp_t e;
      if (bus.out_valid && bus.out_ready) begin
         check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            $display("xfer res=0x%08h rd=%0d ctl=%b sdata=0x%08h", bus.out_res, bus.out_rd,
                     {bus.out_regwrite, bus.out_memread, bus.out_memwrite}, bus.out_store_data);
            check("xfer_res", bus.out_res, e.res);
            check("xfer_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
            check("xfer_ctl", {29'd0, bus.out_regwrite, bus.out_memread, bus.out_memwrite},
                  {29'd0, e.ctl});
            check("xfer_sdata", bus.out_store_data, e.sdata);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      bus.out_ready = 1'b1;
      bus.exc_ack   = 1'b0;
      drive(32'hdead_beef, 5'd7, 1, 0, 0, 32'h0, 2'd3, 0, 0, 32'h0, 32'h44, 1'b0);

      // Reset held for three cycles with in_valid high
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_redirect", {31'd0, bus.redirect}, 32'd0);
      check("rst_exc_pending", {31'd0, bus.exc_pending}, 32'd0);
      check("rst_out_res", bus.out_res, 32'd0);
      idle();
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_fwd_en", {31'd0, bus.fwd_en}, 32'd0);
      check("rst_exc_pc", bus.exc_pc, 32'd0);
      check("rst_redirect_pc", bus.redirect_pc, 32'd0);
      @(negedge clk);

      // Back-to-back ADDs to rd=3
      for (int i = 0; i < 3; i++) begin
         drive(32'd5 + 32'(2 * i), 5'd3, 1, 0, 0, 32'h0, 2'd0, 0, 0, 32'h10 + 32'(4 * i), 32'h0, 1'b0);
         push(32'd5 + 32'(2 * i), 5'd3, 1, 0, 0, 32'h0);
         tick();
         check("b2b_out_res", bus.out_res, 32'd5 + 32'(2 * i));
         check("b2b_fwd_en", {31'd0, bus.fwd_en}, 32'd1);
         check("b2b_fwd_rd", {27'd0, bus.fwd_rd}, 32'd3);
         check("b2b_fwd_data", bus.fwd_data, 32'd5 + 32'(2 * i));
      end
      idle();
      tick();
      check("b2b_drained", {31'd0, bus.out_valid}, 32'd0);

      // Backpressure on a store
      bus.out_ready = 1'b0;
      drive(32'h1234, 5'd0, 0, 0, 1, 32'hcafe_0001, 2'd0, 0, 0, 32'h20, 32'h0, 1'b0);
      push(32'h1234, 5'd0, 0, 0, 1, 32'hcafe_0001);
      tick();
      drive(32'h5678, 5'd9, 1, 1, 0, 32'h0, 2'd0, 0, 0, 32'h24, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
         check("bp_hold_res", bus.out_res, 32'h1234);
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
      push(32'h5678, 5'd9, 1, 1, 0, 32'h0);
      tick();
      check("bp_next_res", bus.out_res, 32'h5678);
      check("bp_fwd_en_x0", {31'd0, bus.fwd_en}, 32'd1);
      idle();
      tick();

      // BEQ taken, BNE not taken, JAL taken with link value
      drive(32'h0, 5'd0, 0, 0, 0, 32'h0, 2'd1, 1, 0, 32'h30, 32'h100, 1'b0);
      push(32'h0, 5'd0, 0, 0, 0, 32'h0);
      tick();
      check("beq_redirect", {31'd0, bus.redirect}, 32'd1);
      check("beq_redirect_pc", bus.redirect_pc, 32'h100);
      drive(32'h0, 5'd0, 0, 0, 0, 32'h0, 2'd2, 1, 0, 32'h34, 32'h200, 1'b0);
      push(32'h0, 5'd0, 0, 0, 0, 32'h0);
      tick();
      check("bne_no_redirect", {31'd0, bus.redirect}, 32'd0);
      drive(32'h3c, 5'd1, 1, 0, 0, 32'h0, 2'd3, 0, 0, 32'h38, 32'h300, 1'b0);
      push(32'h3c, 5'd1, 1, 0, 0, 32'h0);
      tick();
      check("jal_redirect", {31'd0, bus.redirect}, 32'd1);
      check("jal_redirect_pc", bus.redirect_pc, 32'h300);
      check("jal_link_fwd", bus.fwd_data, 32'h3c);
      idle();
      tick();
      check("redirect_one_cycle", {31'd0, bus.redirect}, 32'd0);

      // DIV by zero raises a sticky exception
      drive(32'hffff_ffff, 5'd6, 1, 0, 0, 32'h0, 2'd0, 0, 1, 32'h40, 32'h0, 1'b0);
      tick();
      check("exc_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("exc_pending", {31'd0, bus.exc_pending}, 32'd1);
      check("exc_pc", bus.exc_pc, 32'h40);
      check("exc_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("exc_no_redirect", {31'd0, bus.redirect}, 32'd0);
      drive(32'h99, 5'd2, 1, 0, 0, 32'h0, 2'd0, 0, 0, 32'h44, 32'h0, 1'b0);
      repeat (2) tick();
      check("exc_blocks_accept", {31'd0, bus.out_valid}, 32'd0);
      check("exc_still_pending", {31'd0, bus.exc_pending}, 32'd1);
      idle();
      bus.exc_ack = 1'b1;
      tick();
      bus.exc_ack = 1'b0;
      check("ack_clears", {31'd0, bus.exc_pending}, 32'd0);
      check("ack_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("ack_exc_pc_held", bus.exc_pc, 32'h40);
      bus.exc_ack = 1'b1;
      tick();
      bus.exc_ack = 1'b0;
      check("idle_ack_no_effect", {31'd0, bus.exc_pending}, 32'd0);

      // Flush beats illegal and a taken JAL
      drive(32'h84, 5'd1, 1, 0, 0, 32'h0, 2'd3, 0, 1, 32'h80, 32'h500, 1'b1);
      tick();
      check("flush_no_redirect", {31'd0, bus.redirect}, 32'd0);
      check("flush_no_exc", {31'd0, bus.exc_pending}, 32'd0);
      check("flush_bubble", {31'd0, bus.out_valid}, 32'd0);
      check("flush_exc_pc_kept", bus.exc_pc, 32'h40);
      idle();
      tick();

      // Asynchronous reset in the middle of a held, redirecting payload
      bus.out_ready = 1'b0;
      drive(32'h77, 5'd5, 1, 0, 0, 32'h0, 2'd1, 1, 0, 32'h90, 32'h600, 1'b0);
      tick();
      check("mid_valid_before", {31'd0, bus.out_valid}, 32'd1);
      check("mid_redirect_before", {31'd0, bus.redirect}, 32'd1);
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("mid_rst_redirect", {31'd0, bus.redirect}, 32'd0);
      check("mid_rst_redirect_pc", bus.redirect_pc, 32'd0);
      check("mid_rst_res", bus.out_res, 32'd0);
      check("mid_rst_exc_pc", bus.exc_pc, 32'd0);
      sb.delete();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      tick();

      check("sb_empty_at_end", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline register directly downstream of the combinational ALU in the execute stage.
- Captures the ALU result, zero flag and illegal_op, together with instruction metadata, and hands them to the memory stage over a valid/ready handshake.
- Resolves conditional branches and jumps from the zero flag, issuing a one-cycle PC redirect.
- Converts illegal_op (divide or remainder by zero) into a sticky exception record, held until acknowledged.

Parameters:
- XLEN, 32, datapath width of result, PC and store data
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- alu_res  in  XLEN  ALU result
- alu_zero  in  1  ALU zero flag
- alu_illegal  in  1  ALU illegal_op
- in_pc  in  XLEN  instruction PC
- in_rd  in  REG_ADDR_W  destination register
- in_regwrite  in  1  instruction writes rd
- in_memread  in  1  load
- in_memwrite  in  1  store
- in_store_data  in  XLEN  rs2 value for stores
- in_br_type  in  2  0 none, 1 BEQ, 2 BNE, 3 JAL/JALR (unconditional)
- in_br_target  in  XLEN  computed branch target
- flush  in  1  kill the instruction being captured this cycle
- out_valid  out  1  MEM stage payload valid
- out_ready  in  1  MEM stage accepts
- out_res, out_store_data  out  XLEN  registered payload
- out_rd  out  REG_ADDR_W  registered payload
- out_regwrite, out_memread, out_memwrite  out  1  registered control
- redirect  out  1  one-cycle PC redirect pulse
- redirect_pc  out  XLEN  redirect target
- fwd_en  out  1  out_valid & out_regwrite & (out_rd != 0)
- fwd_rd  out  REG_ADDR_W  equals out_rd
- fwd_data  out  XLEN  equals out_res
- exc_pending  out  1  sticky exception flag
- exc_pc  out  XLEN  PC of the faulting instruction
- exc_ack  in  1  trap handler acknowledges

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0, including out_valid, redirect, redirect_pc, exc_pending, exc_pc and all payload fields.
- in_ready = !exc_pending & (!out_valid | out_ready). This is combinational, with no combinational path from in_valid.
- accept = in_valid & in_ready. Latency is one cycle from accept to out_valid.
- On a rising edge with accept & !flush & !alu_illegal:
  - Load all payload fields.
  - out_valid <= 1.
- On a rising edge with accept & alu_illegal & !flush:
  - Set exc_pending <= 1 and exc_pc <= in_pc.
  - The payload is killed: out_valid <= 0 and all control fields 0, so there is no writeback and no memory access.
  - No redirect is issued.
- On a rising edge with accept & flush: a bubble is inserted (out_valid <= 0, control 0). There is no exception and no redirect. Flush has priority over illegal and branch.
- On a rising edge with out_valid & out_ready & !accept: out_valid <= 0.
- Otherwise (stall, out_valid & !out_ready): every payload field holds.
- Branch resolution happens at the accepting edge of a non-flushed, non-illegal instruction:
  - taken = (br_type==1 & alu_zero) | (br_type==2 & !alu_zero) | (br_type==3).
  - If taken: redirect <= 1 and redirect_pc <= in_br_target for exactly one cycle. Otherwise redirect <= 0.
  - For JAL/JALR the ALU result (link value) still flows to writeback.
- Exception handling:
  - exc_pending remains 1 until a cycle with exc_ack high, then clears on that edge.
  - exc_pc holds its value until the next exception is captured.
  - exc_ack while exc_pending=0 has no effect.
  - While exc_pending=1, no new instruction is accepted. Any payload already held still drains to the MEM stage.
- Simultaneous drain and accept (out_valid & out_ready & accept): the new payload replaces the old on the same edge, giving full throughput of one instruction per cycle.
- Forwarding outputs are combinational from the registered payload and never come from the in_* inputs.
- Reset asserted mid-operation: the pending exception, redirect and payload are all discarded immediately.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> all outputs 0 and in_ready=1 after release (out_valid=0).
- Back-to-back ADD results 5, 7, 9 with out_ready=1, rd=3 -> out_res = 5, 7, 9 on consecutive cycles, and fwd_en=1, fwd_rd=3 each cycle.
- Backpressure: out_ready=0 for 4 cycles after capturing res=0x1234 -> in_ready=0 and out_res holds 0x1234; on release, the next instruction is accepted in the same cycle.
- BEQ with alu_zero=1 and target 0x100, then BNE with alu_zero=1 -> a single redirect pulse with redirect_pc=0x100 for the first; no pulse for the second.
- DIV with alu_illegal=1 at pc 0x40, regwrite=1 -> out_valid stays 0, exc_pending=1, exc_pc=0x40 and in_ready=0; exc_ack for one cycle clears exc_pending and in_ready returns to 1.
- flush asserted together with a taken JAL that also has alu_illegal=1 -> bubble only: no redirect and exc_pending stays 0.
